// File: rtl/gobou_net_loader.sv
// gobou_net_loader
//   Streaming weight loader for the gobou fully-connected engine. Accepts a
//   flat stream of per-neuron weight vectors (N_IN weights then the bias)
//   over valid/ready and scatters it into the CORE per-core net memories in
//   gobou layout: neuron k lands in core k % CORE at base (N_IN+1)*(k/CORE).
//
//   Optional feature macro: GOBOU_LOADER_PAD_EN
//     defined   - cores with no neuron in the final group get that group's
//                 slot zero-filled (S_PAD), so stale weights never survive.
//     undefined - S_PAD is not built; loading ends after the last beat.
//
// Ports
//   clk, xrst          clock, asynchronous active-low reset
//   req                start pulse, sampled only in S_IDLE
//   total_in/total_out N_IN / N_OUT, latched on an accepted req
//   s_valid/s_data     stream beat (signed)
//   s_ready            high throughout S_LOAD (no backpressure)
//   net_we             0 = no write, n+1 = write core n
//   net_addr/write_net net memory address / signed write data
//   busy               high in S_LOAD, S_PAD and S_DONE
//   ack                one-cycle completion pulse
module gobou_net_loader #(
  parameter int DWIDTH  = 16,
  parameter int CORE    = 8,
  parameter int CORELOG = 3,
  parameter int NETSIZE = 14,
  parameter int LWIDTH  = 10
) (
  input  logic                      clk,
  input  logic                      xrst,
  input  logic                      req,
  input  logic [LWIDTH-1:0]         total_in,
  input  logic [LWIDTH-1:0]         total_out,
  input  logic                      s_valid,
  input  logic signed [DWIDTH-1:0]  s_data,
  output logic                      s_ready,
  output logic [CORELOG:0]          net_we,
  output logic [NETSIZE-1:0]        net_addr,
  output logic signed [DWIDTH-1:0]  write_net,
  output logic                      busy,
  output logic                      ack
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_PAD, S_DONE} state_t;

  localparam logic [CORELOG:0] C_LAST = (CORELOG+1)'(CORE-1);

  state_t             state;
  // tail holds S_DONE for one extra cycle so ack trails the final write
  // (which is registered) by exactly one cycle.
  logic               tail;
  logic [LWIDTH-1:0]  n_in, n_out;
  logic [LWIDTH-1:0]  j;      // word within neuron, 0..N_IN
  logic [LWIDTH-1:0]  k;      // neuron index
  logic [CORELOG:0]   c;      // target core
  logic [NETSIZE-1:0] b;      // base address of the current core group

  logic j_wrap, c_wrap, last_neuron, step;

  assign j_wrap      = (j == n_in);
  assign c_wrap      = (c == C_LAST);
  assign last_neuron = (k == n_out - LWIDTH'(1));
  // one word (data or pad) is written this cycle
  assign step        = ((state == S_LOAD) && s_valid) || (state == S_PAD);

  assign s_ready = (state == S_LOAD);
  assign busy    = (state != S_IDLE);
  assign ack     = (state == S_DONE) && !tail;

  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      state     <= S_IDLE;
      tail      <= 1'b0;
      n_in      <= '0;
      n_out     <= '0;
      j         <= '0;
      k         <= '0;
      c         <= '0;
      b         <= '0;
      net_we    <= '0;
      net_addr  <= '0;
      write_net <= '0;
    end else begin
      net_we <= '0;

      if (step) begin
        net_we    <= c + (CORELOG+1)'(1);
        net_addr  <= b + NETSIZE'(j);
        write_net <= (state == S_LOAD) ? s_data : '0;
        if (j_wrap) begin
          j <= '0;
          k <= k + LWIDTH'(1);
          if (c_wrap) begin
            c <= '0;
            b <= b + NETSIZE'(n_in) + NETSIZE'(1);
          end else begin
            c <= c + (CORELOG+1)'(1);
          end
        end else begin
          j <= j + LWIDTH'(1);
        end
      end

      case (state)
        S_IDLE: if (req) begin
          n_in  <= total_in;
          n_out <= total_out;
          j     <= '0;
          k     <= '0;
          c     <= '0;
          b     <= '0;
          tail  <= 1'b0;
          state <= (total_out == '0) ? S_DONE : S_LOAD;
        end
        S_LOAD: if (s_valid && j_wrap && last_neuron) begin
`ifdef GOBOU_LOADER_PAD_EN
          // c_wrap here means N_OUT filled the last group exactly
          if (!c_wrap) begin
            state <= S_PAD;
          end else begin
            state <= S_DONE;
            tail  <= 1'b1;
          end
`else
          state <= S_DONE;
          tail  <= 1'b1;
`endif
        end
`ifdef GOBOU_LOADER_PAD_EN
        S_PAD: if (j_wrap && c_wrap) begin
          state <= S_DONE;
          tail  <= 1'b1;
        end
`endif
        S_DONE: begin
          if (tail) tail  <= 1'b0;
          else      state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gobou_net_loader.sv
module tb_gobou_net_loader;

  localparam int DW = 16, CORE = 2, CL = 1, NS = 14, LW = 10;
`ifdef GOBOU_LOADER_PAD_EN
  localparam bit PAD = 1'b1;
`else
  localparam bit PAD = 1'b0;
`endif

  logic                  clk, xrst, req, s_valid, s_ready, busy, ack;
  logic [LW-1:0]         total_in, total_out;
  logic signed [DW-1:0]  s_data, write_net;
  logic [CL:0]           net_we;
  logic [NS-1:0]         net_addr;

  gobou_net_loader #(.DWIDTH(DW), .CORE(CORE), .CORELOG(CL), .NETSIZE(NS), .LWIDTH(LW)) dut (
    .clk(clk), .xrst(xrst), .req(req), .total_in(total_in), .total_out(total_out),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready), .net_we(net_we),
    .net_addr(net_addr), .write_net(write_net), .busy(busy), .ack(ack));

  typedef struct packed { int core; int addr; int data; int cyc; } wr_t;

  int checks = 0, passed = 0, cyc = 0;
  int t0, exp_ack, rdy_bad;
  logic rdy_after;
  wr_t obs[$], exp_q[$];
  int ack_cyc[$], acc_cyc[$];
  logic signed [DW-1:0] stim[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // observed write / ack trace, sampled mid-cycle
  always @(negedge clk) if (xrst) begin
    if (net_we != 0) obs.push_back('{int'(net_we) - 1, int'(net_addr), int'(write_net), cyc});
    if (ack) ack_cyc.push_back(cyc);
  end

  // Reference: neuron k word w -> core k%CORE, addr (N_IN+1)*(k/CORE)+w,
  // written the cycle after its beat is accepted; pad words follow back to back.
  function automatic void build_exp(input int n_in, input int n_out);
    int nw, last, grp;
    wr_t e;
    nw = n_in + 1;
    last = t0;
    exp_q.delete();
    for (int kk = 0; kk < n_out; kk++)
      for (int w = 0; w < nw; w++) begin
        e.core = kk % CORE;
        e.addr = (nw * (kk / CORE) + w) % (1 << NS);
        e.data = int'(stim[kk * nw + w]);
        e.cyc  = acc_cyc[kk * nw + w];
        last   = e.cyc;
        exp_q.push_back(e);
      end
    grp = ((n_out + CORE - 1) / CORE) * CORE;
    if (PAD && (n_out % CORE) != 0)
      for (int kk = n_out; kk < grp; kk++)
        for (int w = 0; w < nw; w++) begin
          e.core = kk % CORE;
          e.addr = (nw * (kk / CORE) + w) % (1 << NS);
          e.data = 0;
          last   = last + 1;
          e.cyc  = last;
          exp_q.push_back(e);
        end
    exp_ack = last + 1;
  endfunction

  // Drives one load; stop>=0 truncates the stream after that many beats.
  task automatic do_load(input int n_in, input int n_out, input int gap, input bit dup, input int stop);
    int nwords, idx, t;
    logic v;
    obs.delete(); ack_cyc.delete(); acc_cyc.delete();
    rdy_bad = 0;
    @(negedge clk);
    total_in = LW'(n_in); total_out = LW'(n_out); req = 1'b1; t0 = cyc;
    @(negedge clk);
    req = 1'b0;
    nwords = (n_out == 0) ? 0 : (n_in + 1) * n_out;
    if (stop >= 0 && stop < nwords) nwords = stop;
    idx = 0; t = 0;
    while (idx < nwords && t < 4000) begin
      v = (gap == 0) ? 1'b1 : (gap == 1) ? (t % 3 == 0) : 1'($urandom_range(0, 1));
      if (s_ready !== 1'b1) rdy_bad++;
      s_valid = v;
      s_data  = v ? stim[idx] : DW'($urandom);
      req     = dup && (t == 2);
      if (v) begin acc_cyc.push_back(cyc + 1); idx++; end
      @(negedge clk); t++;
    end
    s_valid = 1'b0; req = 1'b0; s_data = DW'($urandom);
    rdy_after = s_ready;
  endtask

  task automatic fill_seq(input int n);
    stim.delete();
    for (int i = 1; i <= n; i++) stim.push_back(DW'(i));
  endtask

  task automatic fill_rand(input int n);
    stim.delete();
    for (int i = 0; i < n; i++) stim.push_back(DW'($urandom));
  endtask

  task automatic test_reset;
    #2;
    checks++;
    if ({s_ready, net_we, net_addr, write_net, busy, ack} === '0) passed++;
    else $display("FAIL reset_outputs got %b want 0", {s_ready, net_we, net_addr, write_net, busy, ack});
    repeat (2) @(negedge clk);
    xrst = 1'b1;
  endtask

  task automatic test_basic;
    int n;
    fill_seq(10);
    do_load(4, 2, 0, 1'b1, -1);   // second req during S_LOAD must be ignored
    n = 0;
    while (!ack && n < 40) begin @(negedge clk); n++; end
    @(negedge clk);
    checks++;
    if (busy === 1'b0 && ack === 1'b0) passed++;
    else $display("FAIL basic_idle_after_ack got busy=%b ack=%b want 0 0", busy, ack);
    repeat (8) @(negedge clk);
    build_exp(4, 2);
    checks++;
    if (obs.size() == exp_q.size()) passed++;
    else $display("FAIL basic_nwrites got %0d want %0d", obs.size(), exp_q.size());
    foreach (exp_q[i]) if (i < obs.size()) begin
      checks++;
      if (obs[i] == exp_q[i]) passed++;
      else $display("FAIL basic_write%0d got c%0d a%0d d%0d @%0d want c%0d a%0d d%0d @%0d", i,
        obs[i].core, obs[i].addr, obs[i].data, obs[i].cyc, exp_q[i].core, exp_q[i].addr, exp_q[i].data, exp_q[i].cyc);
    end
    checks++;
    if (ack_cyc.size() == 1 && ack_cyc[0] == exp_ack) passed++;
    else $display("FAIL basic_ack got n=%0d @%0d want 1 @%0d", ack_cyc.size(), (ack_cyc.size() > 0) ? ack_cyc[0] : -1, exp_ack);
    checks++;
    if (rdy_bad == 0 && rdy_after === 1'b0) passed++;
    else $display("FAIL basic_ready got drops=%0d after=%b want 0 0", rdy_bad, rdy_after);
  endtask

  task automatic test_pad;
    fill_seq(15);
    do_load(4, 3, 0, 1'b0, -1);
    repeat (12) @(negedge clk);
    build_exp(4, 3);
    checks++;
    if (obs.size() == exp_q.size()) passed++;
    else $display("FAIL pad_nwrites got %0d want %0d", obs.size(), exp_q.size());
    foreach (exp_q[i]) if (i < obs.size()) begin
      checks++;
      if (obs[i] == exp_q[i]) passed++;
      else $display("FAIL pad_write%0d got c%0d a%0d d%0d @%0d want c%0d a%0d d%0d @%0d", i,
        obs[i].core, obs[i].addr, obs[i].data, obs[i].cyc, exp_q[i].core, exp_q[i].addr, exp_q[i].data, exp_q[i].cyc);
    end
    checks++;
    if (ack_cyc.size() == 1 && ack_cyc[0] == exp_ack) passed++;
    else $display("FAIL pad_ack got n=%0d @%0d want 1 @%0d", ack_cyc.size(), (ack_cyc.size() > 0) ? ack_cyc[0] : -1, exp_ack);
  endtask

  task automatic test_gaps;
    fill_seq(10);
    do_load(4, 2, 1, 1'b0, -1);
    repeat (8) @(negedge clk);
    build_exp(4, 2);
    checks++;
    if (obs.size() == exp_q.size()) passed++;
    else $display("FAIL gaps_nwrites got %0d want %0d", obs.size(), exp_q.size());
    foreach (exp_q[i]) if (i < obs.size()) begin
      checks++;
      if (obs[i] == exp_q[i]) passed++;
      else $display("FAIL gaps_write%0d got c%0d a%0d d%0d @%0d want c%0d a%0d d%0d @%0d", i,
        obs[i].core, obs[i].addr, obs[i].data, obs[i].cyc, exp_q[i].core, exp_q[i].addr, exp_q[i].data, exp_q[i].cyc);
    end
    checks++;
    if (rdy_bad == 0 && rdy_after === 1'b0) passed++;
    else $display("FAIL gaps_ready got drops=%0d after=%b want 0 0", rdy_bad, rdy_after);
    checks++;
    if (ack_cyc.size() == 1 && ack_cyc[0] == exp_ack) passed++;
    else $display("FAIL gaps_ack got n=%0d @%0d want 1 @%0d", ack_cyc.size(), (ack_cyc.size() > 0) ? ack_cyc[0] : -1, exp_ack);
  endtask

  task automatic test_zero_in;
    fill_rand(3);
    do_load(0, 3, 0, 1'b0, -1);
    repeat (6) @(negedge clk);
    build_exp(0, 3);
    checks++;
    if (obs.size() == exp_q.size()) passed++;
    else $display("FAIL zin_nwrites got %0d want %0d", obs.size(), exp_q.size());
    foreach (exp_q[i]) if (i < obs.size()) begin
      checks++;
      if (obs[i] == exp_q[i]) passed++;
      else $display("FAIL zin_write%0d got c%0d a%0d d%0d @%0d want c%0d a%0d d%0d @%0d", i,
        obs[i].core, obs[i].addr, obs[i].data, obs[i].cyc, exp_q[i].core, exp_q[i].addr, exp_q[i].data, exp_q[i].cyc);
    end
    checks++;
    if (ack_cyc.size() == 1 && ack_cyc[0] == exp_ack) passed++;
    else $display("FAIL zin_ack got n=%0d @%0d want 1 @%0d", ack_cyc.size(), (ack_cyc.size() > 0) ? ack_cyc[0] : -1, exp_ack);
  endtask

  task automatic test_empty;
    stim.delete();
    do_load(3, 0, 0, 1'b0, -1);
    repeat (4) @(negedge clk);
    checks++;
    if (obs.size() == 0) passed++;
    else $display("FAIL empty_nwrites got %0d want 0", obs.size());
    checks++;
    if (ack_cyc.size() == 1 && ack_cyc[0] == t0 + 1) passed++;
    else $display("FAIL empty_ack got n=%0d @%0d want 1 @%0d", ack_cyc.size(), (ack_cyc.size() > 0) ? ack_cyc[0] : -1, t0 + 1);
  endtask

  task automatic test_reset_mid;
    fill_rand(15);
    do_load(4, 3, 0, 1'b0, 3);
    xrst = 1'b0;
    #1;
    checks++;
    if ({s_ready, net_we, net_addr, write_net, busy, ack} === '0) passed++;
    else $display("FAIL midreset_outputs got %b want 0", {s_ready, net_we, net_addr, write_net, busy, ack});
    @(negedge clk);
    xrst = 1'b1;
    fill_rand(10);
    do_load(4, 2, 0, 1'b0, -1);
    repeat (8) @(negedge clk);
    build_exp(4, 2);
    checks++;
    if (obs.size() == exp_q.size()) passed++;
    else $display("FAIL midreset_nwrites got %0d want %0d", obs.size(), exp_q.size());
    foreach (exp_q[i]) if (i < obs.size()) begin
      checks++;
      if (obs[i] == exp_q[i]) passed++;
      else $display("FAIL midreset_write%0d got c%0d a%0d d%0d @%0d want c%0d a%0d d%0d @%0d", i,
        obs[i].core, obs[i].addr, obs[i].data, obs[i].cyc, exp_q[i].core, exp_q[i].addr, exp_q[i].data, exp_q[i].cyc);
    end
    checks++;
    if (ack_cyc.size() == 1 && ack_cyc[0] == exp_ack) passed++;
    else $display("FAIL midreset_ack got n=%0d @%0d want 1 @%0d", ack_cyc.size(), (ack_cyc.size() > 0) ? ack_cyc[0] : -1, exp_ack);
  endtask

  task automatic test_random;
    int ni, no;
    for (int r = 0; r < 4; r++) begin
      ni = $urandom_range(0, 5);
      no = $urandom_range(1, 6);
      fill_rand((ni + 1) * no);
      do_load(ni, no, 2, 1'b0, -1);
      repeat (CORE * (ni + 1) + 6) @(negedge clk);
      build_exp(ni, no);
      checks++;
      if (obs.size() == exp_q.size()) passed++;
      else $display("FAIL rand%0d_nwrites got %0d want %0d", r, obs.size(), exp_q.size());
      foreach (exp_q[i]) if (i < obs.size()) begin
        checks++;
        if (obs[i] == exp_q[i]) passed++;
        else $display("FAIL rand%0d_write%0d got c%0d a%0d d%0d @%0d want c%0d a%0d d%0d @%0d", r, i,
          obs[i].core, obs[i].addr, obs[i].data, obs[i].cyc, exp_q[i].core, exp_q[i].addr, exp_q[i].data, exp_q[i].cyc);
      end
      checks++;
      if (ack_cyc.size() == 1 && ack_cyc[0] == exp_ack) passed++;
      else $display("FAIL rand%0d_ack got n=%0d @%0d want 1 @%0d", r, ack_cyc.size(), (ack_cyc.size() > 0) ? ack_cyc[0] : -1, exp_ack);
    end
  endtask

  initial begin
    clk = 1'b0; xrst = 1'b0; req = 1'b0; s_valid = 1'b0; s_data = '0;
    total_in = '0; total_out = '0;
    test_reset;
    test_basic;
    test_pad;
    test_gaps;
    test_zero_in;
    test_empty;
    test_reset_mid;
    test_random;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
